// File: rtl/pdm_audio_tx.sv
// PDM audio transmitter: PCM sample FIFO feeding a first-order sigma-delta modulator.
// Optional dither on the modulator input is enabled with `define PDM_AUDIO_TX_DITHER_EN.
module pdm_audio_tx #(
  parameter int CLK_DIV    = 40,
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic [15:0]                   s_data_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic                          underrun_clr_i,
  output logic                          pdm_data_o,
  output logic                          pdm_en_o,
  output logic                          underrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam int OW = (OSR > 1) ? $clog2(OSR) : 1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            ready_q;
  logic            push, pop, underrun_set;
  logic [DW-1:0]   div_q;
  logic [OW-1:0]   bit_q;
  logic            tick, boundary;
  logic [15:0]     acc_q, sample_q, u;
  logic [16:0]     sum;
  logic            pdm_data_q, pdm_en_q, underrun_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Ready comes from a register so it stays low in the cycle right after reset.
  assign push     = s_valid_i & ready_q;
  assign tick     = (state_q == RUN) && (div_q == DW'(CLK_DIV - 1));
  assign boundary = tick && (bit_q == OW'(OSR - 1));
  assign u        = {~sample_q[15], sample_q[14:0]};

`ifdef PDM_AUDIO_TX_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= 16'hACE1;
    end else if (state_q != IDLE && tick) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign sum = {1'b0, acc_q} + {1'b0, u} + {15'b0, lfsr_q[1:0]};
`else
  assign sum = {1'b0, acc_q} + {1'b0, u};
`endif

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    underrun_set = 1'b0;
    case (state_q)
      IDLE:  if (en_i) state_d = PRIME;
      PRIME: begin
        if (!en_i) begin
          state_d = IDLE;
        end else if (level_q != '0) begin
          pop     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (boundary) begin
          if (!en_i)                state_d      = IDLE;
          else if (level_q != '0)   pop          = 1'b1;
          else                      underrun_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= s_data_i;
  end

  // An underrun set on a boundary outranks a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b0;
      div_q      <= '0;
      bit_q      <= '0;
      acc_q      <= '0;
      sample_q   <= '0;
      pdm_data_q <= 1'b0;
      pdm_en_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      ready_q  <= (level_d < LW'(FIFO_DEPTH));
      pdm_en_q <= (state_q == RUN);
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        sample_q <= mem[rd_ptr_q];
      end
      if (underrun_set)        underrun_q <= 1'b1;
      else if (underrun_clr_i) underrun_q <= 1'b0;

      if (state_q != RUN) begin
        div_q <= '0;
        bit_q <= '0;
      end else begin
        div_q <= tick ? '0 : div_q + DW'(1);
        if (tick) bit_q <= (bit_q == OW'(OSR - 1)) ? '0 : bit_q + OW'(1);
      end

      // The accumulator carries across samples and is only cleared while idle.
      if (state_q == IDLE) begin
        acc_q      <= '0;
        pdm_data_q <= 1'b0;
      end else if (tick) begin
        acc_q      <= sum[15:0];
        pdm_data_q <= sum[16];
      end
    end
  end

  assign s_ready_o    = ready_q;
  assign pdm_data_o   = pdm_data_q;
  assign pdm_en_o     = pdm_en_q;
  assign underrun_o   = underrun_q;
  assign fifo_level_o = level_q;

endmodule

// File: tb/tb_pdm_audio_tx.sv
// Self-checking bench for pdm_audio_tx: a sigma-delta model fills an expected-bit
// queue as samples are queued, and each bit is popped and compared at its tick.
module tb_pdm_audio_tx;

  localparam int CLK_DIV    = 40;
  localparam int OSR        = 64;
  localparam int FIFO_DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [15:0] s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic        underrun_clr_i;
  logic        pdm_data_o;
  logic        pdm_en_o;
  logic        underrun_o;
  logic [2:0]  fifo_level_o;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          next_wait    = CLK_DIV;
  logic [15:0] m_acc        = 16'h0000;
  logic        exp_q[$];

  pdm_audio_tx #(
    .CLK_DIV(CLK_DIV),
    .OSR(OSR),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i(en_i),
    .s_data_i(s_data_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .underrun_clr_i(underrun_clr_i),
    .pdm_data_o(pdm_data_o),
    .pdm_en_o(pdm_en_o),
    .underrun_o(underrun_o),
    .fifo_level_o(fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference modulator: appends one frame of expected bits for sample s.
  task automatic expect_frame(input logic [15:0] s);
    logic [15:0] uu;
    logic [16:0] total;
    uu = {~s[15], s[14:0]};
    for (int i = 0; i < OSR; i++) begin
      total = {1'b0, m_acc} + {1'b0, uu};
      m_acc = total[15:0];
      exp_q.push_back(total[16]);
    end
  endtask

  // Called at a negedge; pushes one sample and reports clock edges consumed.
  task automatic applyStimulus(input logic [15:0] d, input bit do_model, output int cycles);
    bit ok;
    cycles    = 0;
    ok        = 1'b0;
    s_data_i  = d;
    s_valid_i = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = s_ready_o;
      @(posedge clk_i);
      cycles++;
      @(negedge clk_i);
    end
    s_valid_i = 1'b0;
    checkOutput("push_accept", 32'(ok), 32'd1);
    if (do_model) expect_frame(d);
  endtask

  task automatic sync_run();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_i);
      seen = pdm_en_o;
    end
    checkOutput("en_rise", 32'(seen), 32'd1);
    next_wait = CLK_DIV - 1;
  endtask

  task automatic check_bits(input int n, input string tag, output int ones, output logic first);
    logic e;
    ones  = 0;
    first = 1'bx;
    for (int i = 0; i < n; i++) begin
      repeat (next_wait) @(posedge clk_i);
      @(negedge clk_i);
      next_wait = CLK_DIV;
      if (exp_q.size() == 0) begin
        checkOutput({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput(tag, 32'(pdm_data_o), 32'(e));
      end
      if (pdm_data_o === 1'b1) ones++;
      if (i == 0) first = pdm_data_o;
    end
  endtask

  initial begin
    int   ones;
    int   cyc;
    int   accepted;
    logic first;
    bit   idle_bad;
    bit   ok;

    rst_i          = 1'b1;
    en_i           = 1'b0;
    s_data_i       = 16'h0000;
    s_valid_i      = 1'b0;
    underrun_clr_i = 1'b0;

    // Reset and idle
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_ready", 32'(s_ready_o), 32'd0);
    checkOutput("rst_en", 32'(pdm_en_o), 32'd0);
    checkOutput("rst_data", 32'(pdm_data_o), 32'd0);
    checkOutput("rst_underrun", 32'(underrun_o), 32'd0);
    checkOutput("rst_level", 32'(fifo_level_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("post_rst_ready", 32'(s_ready_o), 32'd1);
    idle_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (pdm_en_o !== 1'b0 || pdm_data_o !== 1'b0 || underrun_o !== 1'b0 ||
          fifo_level_o !== 3'd0 || s_ready_o !== 1'b1) idle_bad = 1'b1;
    end
    checkOutput("idle_quiet", 32'(idle_bad), 32'd0);

    // Midscale, full-scale positive, full-scale negative, then a quarter-scale sample
    applyStimulus(16'h0000, 1'b1, cyc);
    applyStimulus(16'h7FFF, 1'b1, cyc);
    applyStimulus(16'h8000, 1'b1, cyc);
    applyStimulus(16'h4000, 1'b1, cyc);
    checkOutput("full_level", 32'(fifo_level_o), 32'd4);
    checkOutput("full_ready", 32'(s_ready_o), 32'd0);
    en_i = 1'b1;
    sync_run();
    checkOutput("first_pop_level", 32'(fifo_level_o), 32'd3);
    check_bits(OSR, "mid_bit", ones, first);
    checkOutput("mid_ones", 32'(ones), 32'd32);
    checkOutput("mid_first", 32'(first), 32'd0);
    check_bits(OSR, "max_bit", ones, first);
    checkOutput("max_first", 32'(first), 32'd0);
    checkOutput("max_ones", 32'(ones), 32'd63);
    checkOutput("max_no_underrun", 32'(underrun_o), 32'd0);
    check_bits(OSR, "min_bit", ones, first);
    checkOutput("min_ones", 32'(ones), 32'd0);
    checkOutput("min_no_underrun", 32'(underrun_o), 32'd0);
    checkOutput("drained_level", 32'(fifo_level_o), 32'd0);

    // Underrun: the last sample is held and replayed
    check_bits(OSR - 2, "q_bit", ones, first);
    checkOutput("pre_underrun", 32'(underrun_o), 32'd0);
    expect_frame(16'h4000);
    check_bits(2, "q_bit", ones, first);
    checkOutput("underrun_set", 32'(underrun_o), 32'd1);
    check_bits(10, "hold_bit", ones, first);
    underrun_clr_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    underrun_clr_i = 1'b0;
    next_wait--;
    checkOutput("underrun_clr", 32'(underrun_o), 32'd0);
    check_bits(OSR - 11, "hold_bit", ones, first);
    expect_frame(16'h4000);
    repeat (CLK_DIV - 1) @(posedge clk_i);
    @(negedge clk_i);
    underrun_clr_i = 1'b1;
    next_wait = 1;
    check_bits(1, "hold_bit", ones, first);
    underrun_clr_i = 1'b0;
    checkOutput("set_beats_clr", 32'(underrun_o), 32'd1);

    // Refill during the held frame, then stop mid-frame with samples left queued
    applyStimulus(16'h1234, 1'b1, cyc);
    next_wait -= cyc;
    check_bits(OSR, "hold2_bit", ones, first);
    checkOutput("refill_level", 32'(fifo_level_o), 32'd0);
    applyStimulus(16'hC000, 1'b0, cyc);
    next_wait -= cyc;
    applyStimulus(16'h2000, 1'b0, cyc);
    next_wait -= cyc;
    check_bits(10, "stop_bit", ones, first);
    en_i = 1'b0;
    check_bits(OSR - 10, "stop_bit", ones, first);
    checkOutput("stop_en_last", 32'(pdm_en_o), 32'd1);
    @(negedge clk_i);
    checkOutput("stop_en_off", 32'(pdm_en_o), 32'd0);
    checkOutput("stop_data_off", 32'(pdm_data_o), 32'd0);
    checkOutput("stop_level", 32'(fifo_level_o), 32'd2);
    m_acc = 16'h0000;

    // Restart, then reset in the middle of the frame
    en_i = 1'b1;
    expect_frame(16'hC000);
    sync_run();
    checkOutput("restart_level", 32'(fifo_level_o), 32'd1);
    check_bits(20, "rst_frame_bit", ones, first);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    en_i  = 1'b0;
    checkOutput("midrst_en", 32'(pdm_en_o), 32'd0);
    checkOutput("midrst_data", 32'(pdm_data_o), 32'd0);
    checkOutput("midrst_underrun", 32'(underrun_o), 32'd0);
    checkOutput("midrst_level", 32'(fifo_level_o), 32'd0);
    checkOutput("midrst_ready", 32'(s_ready_o), 32'd0);
    exp_q.delete();
    m_acc = 16'h0000;
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("midrst_ready_back", 32'(s_ready_o), 32'd1);

    // Backpressure: six offers against a four-entry FIFO
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      s_data_i  = 16'(i + 1);
      s_valid_i = 1'b1;
      ok        = s_ready_o;
      @(posedge clk_i);
      if (ok) accepted++;
      @(negedge clk_i);
    end
    s_valid_i = 1'b0;
    for (int i = 1; i <= 4; i++) expect_frame(16'(i));
    checkOutput("bp_accepted", 32'(accepted), 32'd4);
    checkOutput("bp_ready", 32'(s_ready_o), 32'd0);
    checkOutput("bp_level", 32'(fifo_level_o), 32'd4);
    en_i = 1'b1;
    sync_run();
    checkOutput("bp_level_1", 32'(fifo_level_o), 32'd3);
    check_bits(OSR, "bp1_bit", ones, first);
    checkOutput("bp_level_2", 32'(fifo_level_o), 32'd2);
    check_bits(OSR, "bp2_bit", ones, first);
    checkOutput("bp_level_3", 32'(fifo_level_o), 32'd1);
    check_bits(OSR, "bp3_bit", ones, first);
    checkOutput("bp_level_4", 32'(fifo_level_o), 32'd0);
    check_bits(10, "bp4_bit", ones, first);
    en_i = 1'b0;
    check_bits(OSR - 10, "bp4_bit", ones, first);
    @(negedge clk_i);
    checkOutput("bp_end_en", 32'(pdm_en_o), 32'd0);
    checkOutput("bp_end_underrun", 32'(underrun_o), 32'd0);
    checkOutput("bp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pdm_audio_tx.md
Name: pdm_audio_tx

Overview:
- PDM transmitter for the audio-out path: the opposite direction to the microphone PDM receiver in the audio front end.
- Accepts signed 16-bit PCM samples over a valid/ready handshake and buffers them in a small FIFO.
- Converts each sample to a 1-bit stream with a first-order sigma-delta modulator at CLK_DIV-divided bit rate, OSR bits per sample.
- Drives the board's PWM/PDM audio amplifier pins (pdm_data_o, pdm_en_o) from the top level.

Parameters:
- CLK_DIV, 40, system clocks per PDM bit (100 MHz / 40 = 2.5 MHz bit rate); must be >= 2.
- OSR, 64, PDM bits per PCM sample (oversampling ratio); must be >= 2.
- FIFO_DEPTH, 4, sample FIFO entries; must be a power of 2.

Ports:
- clk_i  in  1  system clock (100 MHz).
- rst_i  in  1  reset; synchronous, active-high.
- en_i  in  1  run request; level-sensitive.
- s_data_i  in  16  signed two's-complement PCM sample.
- s_valid_i  in  1  s_data_i valid.
- s_ready_o  out  1  FIFO can accept; push occurs when s_valid_i & s_ready_o.
- underrun_clr_i  in  1  clears underrun_o.
- pdm_data_o  out  1  PDM bit stream to audio amplifier.
- pdm_en_o  out  1  amplifier enable; high only while modulating.
- underrun_o  out  1  sticky; FIFO was empty at a sample boundary.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (cycle with rst_i=1):
  - pdm_data_o=0, pdm_en_o=0, underrun_o=0, fifo_level_o=0, s_ready_o=0.
  - FIFO flushed, accumulator=0, current sample=0, divider and bit counters=0, state=IDLE.
  - s_ready_o rises on the first cycle after reset.
  - A reset asserted mid-frame aborts the frame immediately; no partial completion.
- FIFO:
  - s_ready_o = (level < FIFO_DEPTH), computed from the registered level.
  - A push while full is not accepted, even if a pop occurs in the same cycle.
  - A push in the same cycle as a pop leaves the level unchanged.
  - The FIFO accepts pushes in every state, including IDLE.
- Conversion:
  - u = {~s[15], s[14:0]} (offset binary, 16 bits).
  - On every bit tick: {carry, acc[15:0]} <= acc + u, and pdm_data_o <= carry (registered).
- Bit tick: one-cycle pulse, asserted every CLK_DIV clocks while in RUN. The first tick occurs CLK_DIV cycles after entering RUN.
- States:
  - IDLE: pdm_en_o=0, pdm_data_o=0, counters and acc held at 0. Goes to PRIME when en_i=1.
  - PRIME: pdm_en_o=0. When the FIFO is non-empty: pop the head into the current sample, go to RUN. If en_i drops first, return to IDLE.
  - RUN: pdm_en_o=1, registered, so it rises the cycle after entering RUN. Counts ticks 0..OSR-1. On the tick with count OSR-1 (sample boundary):
    - if en_i=0: go to IDLE without popping; pdm_en_o and pdm_data_o go to 0 the next cycle;
    - else if the FIFO is non-empty: pop into the current sample; the next tick uses it;
    - else: hold the current sample and set underrun_o.
  - Deasserting en_i mid-frame always completes the frame to its boundary.
- underrun_o: set at an empty-FIFO boundary in RUN; cleared by underrun_clr_i. If set and clear occur in the same cycle, set wins.
- acc is not cleared between samples in RUN; it clears only in IDLE and on reset.

Optional Feature:
- Macro: PDM_AUDIO_TX_DITHER_EN.
- When defined:
  - A 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 0xACE1 on reset) advances once per bit tick.
  - Its 2 LSBs are zero-extended and added into the modulator: {carry, acc} <= acc + u + lfsr[1:0].
  - The LFSR is held in IDLE.
- When undefined: no LFSR, and the arithmetic is exactly as specified under Behaviour.
- Test plan values below assume the macro is undefined.

Test Plan:
- Reset and idle: assert rst_i 2 cycles, then en_i=0 for 100 cycles -> pdm_en_o=0, pdm_data_o=0, underrun_o=0, fifo_level_o=0, s_ready_o=1 from the first post-reset cycle.
- Midscale: push 0x0000, en_i=1 -> pdm_en_o=1. Sampled at ticks, the bits are 0,1,0,1,...; exactly 32 ones in the 64 bits of the frame.
- Extremes:
  - Push 0x7FFF -> first bit 0, then 63 ones.
  - Then push 0x8000 -> the next 64 bits are all 0, and no underrun as long as a sample is present at each boundary.
- Underrun: push one sample, en_i=1, no further pushes.
  - At the first boundary underrun_o=1 and the bit pattern continues from the held sample.
  - Pulse underrun_clr_i -> 0 the next cycle. If another boundary occurs in the same cycle as the clear, underrun_o stays 1.
- Backpressure: with en_i=0, drive s_valid_i for 6 cycles (values 1..6) -> 4 accepted, s_ready_o=0, fifo_level_o=4. After en_i=1, samples play out in order 1,2,3,4.
- Stop and reset mid-frame:
  - Deassert en_i at tick 10 of a frame -> modulation continues to tick 63, then pdm_en_o=0 on the following cycle, and the FIFO keeps its remaining entries.
  - Separately, pulse rst_i at tick 20 -> all outputs return to reset values the next cycle.
